// File: rtl/reaction_session_ctrl_pkg.sv
// Shared types and constants for the reaction-time session controller.
// Holds the state encoding, LFSR seed/taps and the score width.
package reaction_session_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_GO,
    ST_RESULT,
    ST_FOUL,
    ST_DONE
  } state_t;

  localparam int SCORE_W        = 14;
  localparam int MAX_MS_DEFAULT = 9999;

  // Right-shifting Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/reaction_session_ctrl_lfsr16_delay_gen.sv
// Free-running 16-bit LFSR and the lamp-delay latch loaded once per round.
// The seed is non-zero, so the register can never lock up at all zeros.
module lfsr16_delay_gen
  import reaction_session_ctrl_pkg::*;
#(
  parameter int MIN_DELAY_MS = 2000,
  parameter int SPAN_LOG2    = 12
) (
  input  logic               clk_50M,
  input  logic               clear,
  input  logic               load,
  output logic [SCORE_W-1:0] delay_ms
);

  logic [15:0]        lfsr_reg;
  logic [SCORE_W-1:0] delay_ms_reg;

  always_ff @(posedge clk_50M) begin
    if (clear) begin
      lfsr_reg     <= LFSR_SEED;
      delay_ms_reg <= '0;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
      if (load) begin
        delay_ms_reg <= SCORE_W'(MIN_DELAY_MS) + SCORE_W'(lfsr_reg[SPAN_LOG2-1:0]);
      end
    end
  end

  assign delay_ms = delay_ms_reg;

endmodule

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction-time session sequencer: random lamp delay, ms timing
// of the stop press, foul/timeout detection and last/best/average scoring.
module reaction_session_ctrl
  import reaction_session_ctrl_pkg::*;
#(
  parameter int TICKS_PER_MS = 50000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int SPAN_LOG2    = 12,
  parameter int MAX_MS       = MAX_MS_DEFAULT,
  parameter int GAP_MS       = 1000,
  parameter int ROUNDS_LOG2  = 2
) (
  input  logic                   clk_50M,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   stop,
  output logic                   led,
  output logic                   busy,
  output logic [ROUNDS_LOG2-1:0] round_idx,
  output logic [SCORE_W-1:0]     last_ms,
  output logic [SCORE_W-1:0]     best_ms,
  output logic [SCORE_W-1:0]     avg_ms,
  output logic                   false_start,
  output logic                   timeout,
  output logic                   result_valid,
  output logic                   done
);

  localparam int PS_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int SUM_W = SCORE_W + ROUNDS_LOG2;
  localparam logic [SCORE_W-1:0]     MAX_SCORE  = SCORE_W'(MAX_MS);
  localparam logic [SCORE_W-1:0]     GAP_SCORE  = SCORE_W'(GAP_MS);
  localparam logic [PS_W-1:0]        PS_LAST    = PS_W'(TICKS_PER_MS - 1);
  localparam logic [ROUNDS_LOG2-1:0] LAST_ROUND = '1;

  state_t                 state_reg, state_next;
  logic                   start_d_reg, stop_d_reg;
  logic                   start_rise, stop_rise, state_change, tick, counting;
  logic [PS_W-1:0]        prescale_reg;
  logic [SCORE_W-1:0]     ms_cnt_reg, delay_ms;
  logic [ROUNDS_LOG2-1:0] round_idx_reg;
  logic [SCORE_W-1:0]     last_ms_reg, best_ms_reg, avg_ms_reg;
  logic [SUM_W-1:0]       sum_reg;
  logic                   false_start_reg, timeout_reg, result_valid_reg;

  assign start_rise   = start & ~start_d_reg;
  assign stop_rise    = stop & ~stop_d_reg;
  assign state_change = (state_next != state_reg);
  assign tick         = (prescale_reg == PS_LAST);
  assign counting     = state_reg inside {ST_WAIT, ST_GO, ST_RESULT, ST_FOUL};

  lfsr16_delay_gen #(
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .SPAN_LOG2   (SPAN_LOG2)
  ) u_delay_gen (
    .clk_50M (clk_50M),
    .clear   (clear),
    .load    (state_reg == ST_ARM),
    .delay_ms(delay_ms)
  );

  always_ff @(posedge clk_50M) begin
    if (clear) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // A stop press in WAIT wins over the lamp turning on in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start_rise) state_next = ST_ARM;
      ST_ARM:           state_next = ST_WAIT;
      ST_WAIT: begin
        if (stop_rise)                     state_next = ST_FOUL;
        else if (ms_cnt_reg == delay_ms)   state_next = ST_GO;
      end
      ST_GO: if (stop_rise || ms_cnt_reg == MAX_SCORE) state_next = ST_RESULT;
      ST_RESULT, ST_FOUL: begin
        if (ms_cnt_reg == GAP_SCORE)
          state_next = (round_idx_reg == LAST_ROUND) ? ST_DONE : ST_ARM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    led  = (state_reg == ST_GO);
    busy = !(state_reg == ST_IDLE || state_reg == ST_DONE);
    done = (state_reg == ST_DONE);
  end

  // Edge detectors reset high so a button held through clear is not an edge.
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      start_d_reg      <= 1'b1;
      stop_d_reg       <= 1'b1;
      prescale_reg     <= '0;
      ms_cnt_reg       <= '0;
      round_idx_reg    <= '0;
      last_ms_reg      <= '0;
      best_ms_reg      <= MAX_SCORE;
      avg_ms_reg       <= '0;
      sum_reg          <= '0;
      false_start_reg  <= 1'b0;
      timeout_reg      <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      start_d_reg      <= start;
      stop_d_reg       <= stop;
      result_valid_reg <= 1'b0;
      prescale_reg     <= (state_change || tick) ? '0 : prescale_reg + PS_W'(1);
      if (state_change)          ms_cnt_reg <= '0;
      else if (tick && counting) ms_cnt_reg <= ms_cnt_reg + SCORE_W'(1);

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            sum_reg       <= '0;
            round_idx_reg <= '0;
            best_ms_reg   <= MAX_SCORE;
          end
        end
        ST_ARM: begin
          false_start_reg <= 1'b0;
          timeout_reg     <= 1'b0;
        end
        ST_WAIT: begin
          if (stop_rise) begin
            last_ms_reg      <= MAX_SCORE;
            false_start_reg  <= 1'b1;
            result_valid_reg <= 1'b1;
            sum_reg          <= sum_reg + SUM_W'(MAX_SCORE);
          end
        end
        ST_GO: begin
          if (stop_rise) begin
            last_ms_reg      <= ms_cnt_reg;
            result_valid_reg <= 1'b1;
            sum_reg          <= sum_reg + SUM_W'(ms_cnt_reg);
            if (ms_cnt_reg < best_ms_reg) best_ms_reg <= ms_cnt_reg;
          end else if (ms_cnt_reg == MAX_SCORE) begin
            last_ms_reg      <= MAX_SCORE;
            timeout_reg      <= 1'b1;
            result_valid_reg <= 1'b1;
            sum_reg          <= sum_reg + SUM_W'(MAX_SCORE);
          end
        end
        ST_RESULT, ST_FOUL: begin
          if (state_change) begin
            if (round_idx_reg == LAST_ROUND) avg_ms_reg <= SCORE_W'(sum_reg >> ROUNDS_LOG2);
            else                             round_idx_reg <= round_idx_reg + ROUNDS_LOG2'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign round_idx    = round_idx_reg;
  assign last_ms      = last_ms_reg;
  assign best_ms      = best_ms_reg;
  assign avg_ms       = avg_ms_reg;
  assign false_start  = false_start_reg;
  assign timeout      = timeout_reg;
  assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Self-checking bench for reaction_session_ctrl: table of hand-scored sessions,
// randomized sessions against a cycle-arithmetic reference, and reset corners.
module tb_reaction_session_ctrl;

  localparam int T = 4, DMIN = 3, SPAN = 2, MAXV = 50, GAP = 2, RL2 = 1;
  localparam int M_FOUL = 0, M_REACT = 1, M_TMO = 2;

  typedef struct packed {
    int mode0, off0, mode1, off1;
    int score0, score1, avg, best;
  } vec_t;

  logic clk_50M = 1'b0;
  logic clear = 1'b1, start = 1'b0, stop = 1'b0;
  logic led, busy, false_start, timeout, result_valid, done;
  logic [RL2-1:0] round_idx;
  logic [13:0] last_ms, best_ms, avg_ms;
  int cyc;
  int n_cmp, n_err;
  vec_t vecs[6];

  reaction_session_ctrl #(
    .TICKS_PER_MS(T), .MIN_DELAY_MS(DMIN), .SPAN_LOG2(SPAN),
    .MAX_MS(MAXV), .GAP_MS(GAP), .ROUNDS_LOG2(RL2)
  ) dut (
    .clk_50M(clk_50M), .clear(clear), .start(start), .stop(stop),
    .led(led), .busy(busy), .round_idx(round_idx), .last_ms(last_ms),
    .best_ms(best_ms), .avg_ms(avg_ms), .false_start(false_start),
    .timeout(timeout), .result_valid(result_valid), .done(done)
  );

  always #10 clk_50M = ~clk_50M;

  // cyc == k during the k-th cycle after the last clear edge.
  always @(posedge clk_50M) cyc <= clear ? 0 : cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < n; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_to(input int k);
    if (k < cyc) begin
      n_err++;
      $display("FAIL schedule: at cycle %0d, target %0d already passed", cyc, k);
    end
    while (cyc < k) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_led"}, led, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_round"}, round_idx, 0);
    check({tag, "_last"}, last_ms, 0);
    check({tag, "_best"}, best_ms, MAXV);
    check({tag, "_avg"}, avg_ms, 0);
    check({tag, "_fs"}, false_start, 0);
    check({tag, "_tmo"}, timeout, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Drives one full session starting with a start pulse in cycle s; all check
  // times come from the delay/tick arithmetic, not from watching the DUT.
  task automatic run_session(input int s, input vec_t v, input bit poke);
    int md[2], of[2], sc[2];
    int a, w, g, p, r0, dly, best_exp;
    logic [15:0] lf;
    md[0] = v.mode0; md[1] = v.mode1;
    of[0] = v.off0;  of[1] = v.off1;
    sc[0] = v.score0; sc[1] = v.score1;
    best_exp = MAXV;
    tick_to(s);
    start = 1'b1;
    a = s + 1;
    for (int r = 0; r < 2; r++) begin
      tick_to(a);
      start = 1'b0;
      lf  = lfsr_at(a);
      dly = DMIN + int'(lf[SPAN-1:0]);
      w   = a + 1;
      g   = w + dly * T + 1;
      check("arm_busy", busy, 1);
      check("arm_round", round_idx, r);
      check("arm_led", led, 0);
      check("arm_best", best_ms, best_exp);
      check("arm_done", done, 0);
      tick_to(w);
      if (poke) start = 1'b1;
      if (md[r] == M_FOUL) begin
        p = w + (of[r] % (dly * T + 1));
      end else begin
        tick_to(g - 1);
        check("wait_led", led, 0);
        tick_to(g);
        check("go_led", led, 1);
        p = (md[r] == M_REACT) ? g + of[r] : -1;
      end
      if (p >= 0) begin
        tick_to(p);
        stop = 1'b1;
        r0 = p + 1;
      end else begin
        r0 = g + MAXV * T + 1;
      end
      tick_to(r0 - 1);
      check("rv_early", result_valid, 0);
      tick_to(r0);
      stop  = 1'b0;
      start = 1'b0;
      if (md[r] == M_REACT && sc[r] < best_exp) best_exp = sc[r];
      check("res_rv", result_valid, 1);
      check("res_last", last_ms, sc[r]);
      check("res_fs", false_start, int'(md[r] == M_FOUL));
      check("res_tmo", timeout, int'(md[r] == M_TMO));
      check("res_led", led, 0);
      check("res_best", best_ms, best_exp);
      tick_to(r0 + 1);
      check("rv_pulse", result_valid, 0);
      a = r0 + GAP * T + 1;
    end
    tick_to(a);
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_avg", avg_ms, v.avg);
    check("done_best", best_ms, v.best);
    check("done_round", round_idx, 1);
    check("done_led", led, 0);
    $display("session: modes %0d/%0d scores %0d/%0d -> avg %0d best %0d (dut avg %0d best %0d)",
             v.mode0, v.mode1, v.score0, v.score1, v.avg, v.best, avg_ms, best_ms);
  endtask

  initial begin
    vec_t v;
    int md, off, sc, sum, best, s, a, g;
    logic [15:0] lf;

    // mode0, off0, mode1, off1, score0, score1, avg, best (hand-computed)
    vecs[0] = '{M_REACT, 28, M_REACT, 48, 7, 12, 9, 7};
    vecs[1] = '{M_FOUL, 0, M_REACT, 20, 50, 5, 27, 5};
    vecs[2] = '{M_TMO, 0, M_REACT, 0, 50, 0, 25, 0};
    vecs[3] = '{M_REACT, 44, M_FOUL, 3, 11, 50, 30, 11};
    vecs[4] = '{M_TMO, 0, M_TMO, 0, 50, 50, 50, 50};
    vecs[5] = '{M_REACT, 199, M_REACT, 5, 49, 1, 25, 1};

    // Start held through clear must not launch a session.
    start = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    clear = 1'b0;
    check_reset("rst");
    tick_to(3);
    check("held_start_busy", busy, 0);
    start = 1'b0;
    tick_to(5);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_session(cyc + 1, vecs[i], 1'b0);

    for (int n = 0; n < 10; n++) begin
      sum  = 0;
      best = MAXV;
      v    = '0;
      for (int r = 0; r < 2; r++) begin
        md  = int'($urandom_range(0, 2));
        off = (md == M_REACT) ? int'($urandom_range(0, MAXV * T - 1)) : int'($urandom_range(0, 200));
        sc  = (md == M_REACT) ? off / T : MAXV;
        if (md == M_REACT && sc < best) best = sc;
        sum += sc;
        if (r == 0) begin v.mode0 = md; v.off0 = off; v.score0 = sc; end
        else        begin v.mode1 = md; v.off1 = off; v.score1 = sc; end
      end
      v.avg  = sum / (1 << RL2);
      v.best = best;
      run_session(cyc + int'($urandom_range(1, 6)), v, n[0]);
    end

    // Clear while the lamp is lit returns everything to reset values.
    s = cyc + 2;
    tick_to(s);
    start = 1'b1;
    a = s + 1;
    tick_to(a);
    start = 1'b0;
    lf = lfsr_at(a);
    g  = a + 1 + (DMIN + int'(lf[SPAN-1:0])) * T + 1;
    tick_to(g + 5);
    check("pre_clear_led", led, 1);
    clear = 1'b1;
    @(posedge clk_50M);
    #1;
    clear = 1'b0;
    check_reset("clr");
    tick_to(4);
    check("post_clear_busy", busy, 0);

    run_session(cyc + 1, vecs[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
